// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI transaction controller.
// Holds the state encoding and the Moore output decode.
package spi_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE         = 4'd0,
    GET_ADDR     = 4'd1,
    GOT_ADDR     = 4'd2,
    READ_WAIT    = 4'd3,
    READ_LOAD    = 4'd4,
    READ_SHIFT   = 4'd5,
    WRITE_SHIFT  = 4'd6,
    WRITE_COMMIT = 4'd7,
    DONE         = 4'd8
  } state_t;

  typedef struct packed {
    logic addr_we;
    logic sr_we;
    logic dm_we;
    logic miso_bufe;
    logic busy;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_out(
    input state_t s
  );
    ctrl_out_t o;
    o           = '0;
    o.busy      = (s != IDLE);
    o.addr_we   = (s == GOT_ADDR);
    o.sr_we     = (s == READ_LOAD);
    o.dm_we     = (s == WRITE_COMMIT);
    o.miso_bufe = (s == READ_SHIFT);
    return o;
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Saturating field-bit counter driven by serial-clock edge pulses.
// Clear wins over enable; the count never wraps past width.
module edge_bit_counter #(
  parameter int width = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         en_i,
  output logic [$clog2(width+1)-1:0]   count_o,
  output logic                         done_o
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] MAX = CW'(width);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == MAX);

endmodule

// File: rtl/spi_transaction_ctrl.sv
// SPI slave transaction sequencer: address phase, then read or
// write data phase, with strobes for address, shift reg and memory.
module spi_transaction_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int width = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic rw_bit,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_bufe,
  output logic busy
);

  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  state_t        state_q;
  state_t        state_d;
  ctrl_out_t     out_q;
  ctrl_out_t     out_d;

  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic          cnt_clr;
  logic          cnt_en;
  logic          pulse;

  edge_bit_counter #(
    .width (width)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt),
    .done_o  (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    pulse   = 1'b0;
    if ((state_q != IDLE) && cs_n) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!cs_n) begin
            state_d = GET_ADDR;
            cnt_clr = 1'b1;
          end
        end
        GET_ADDR: begin
          pulse  = sclk_rise;
          cnt_en = pulse && !cnt_done;
          if (cnt_en && (cnt == LAST)) begin
            state_d = GOT_ADDR;
          end
        end
        GOT_ADDR: begin
          if (rw_bit) begin
            state_d = READ_WAIT;
          end else begin
            state_d = WRITE_SHIFT;
            cnt_clr = 1'b1;
          end
        end
        READ_WAIT: begin
          state_d = READ_LOAD;
        end
        READ_LOAD: begin
          state_d = READ_SHIFT;
          cnt_clr = 1'b1;
        end
        READ_SHIFT: begin
          pulse  = sclk_fall;
          cnt_en = pulse && !cnt_done;
          if (cnt_en && (cnt == LAST)) begin
            state_d = DONE;
          end
        end
        WRITE_SHIFT: begin
          pulse  = sclk_rise;
          cnt_en = pulse && !cnt_done;
          if (cnt_en && (cnt == LAST)) begin
            state_d = WRITE_COMMIT;
          end
        end
        WRITE_COMMIT: begin
          state_d = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Outputs are the decode of the state about to be registered,
  // so they flop alongside state_q and never glitch.
  assign out_d = decode_out(state_d);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign addr_we   = out_q.addr_we;
  assign sr_we     = out_q.sr_we;
  assign dm_we     = out_q.dm_we;
  assign miso_bufe = out_q.miso_bufe;
  assign busy      = out_q.busy;

endmodule

// File: doc/spi_transaction_ctrl.md
SPI_TRANSACTION_CTRL -- requirements
Module: spi_transaction_ctrl

Interface
REQ-001 SHALL have parameter: width, 8, bits per address field and per data field (>=2).
REQ-002 SHALL have port: clk  input  1  FPGA clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cs_n  input  1  synchronized chip select, active low; low = transaction active.
REQ-005 SHALL have port: sclk_rise  input  1  one-cycle pulse on serial-clock positive edge (drives shift register peripheralClkEdge).
REQ-006 SHALL have port: sclk_fall  input  1  one-cycle pulse on serial-clock negative edge.
REQ-007 SHALL have port: rw_bit  input  1  shift register parallelDataOut[0]; 1 = read, 0 = write.
REQ-008 SHALL have port: addr_we  output  1  one-cycle enable that latches the address from the shift register.
REQ-009 SHALL have port: sr_we  output  1  one-cycle shift register parallelLoad from data memory.
REQ-010 SHALL have port: dm_we  output  1  one-cycle data memory write enable.
REQ-011 SHALL have port: miso_bufe  output  1  MISO tristate enable; high only in READ_SHIFT.
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, GET_ADDR, GOT_ADDR, READ_WAIT, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_COMMIT, DONE.
REQ-014 SHALL hold a bit counter of clog2(width+1) bits, cleared on every state entry that begins a field.
REQ-015 IDLE: cs_n=0 -> GET_ADDR, counter=0.
REQ-016 GET_ADDR: each sclk_rise increments counter; on the cycle after the width-th sclk_rise -> GOT_ADDR.
REQ-017 GOT_ADDR: addr_we=1 for exactly one cycle; rw_bit=1 -> READ_WAIT, rw_bit=0 -> WRITE_SHIFT with counter=0.
REQ-018 READ_WAIT: one cycle for memory read latency -> READ_LOAD.
REQ-019 READ_LOAD: sr_we=1 for exactly one cycle -> READ_SHIFT, counter=0.
REQ-020 READ_SHIFT: miso_bufe=1; count sclk_fall; after width falls -> DONE.
REQ-021 WRITE_SHIFT: count sclk_rise; after width rises -> WRITE_COMMIT.
REQ-022 WRITE_COMMIT: dm_we=1 for exactly one cycle -> DONE.
REQ-023 DONE: all strobes 0, miso_bufe=0; cs_n=1 -> IDLE; extra sclk edges ignored.
REQ-024 cs_n=1 in any non-IDLE state SHALL force IDLE on the next clk, cancel the transaction and suppress any pending strobe; cs_n has priority over sclk_rise/sclk_fall in the same cycle.
REQ-025 sclk_rise and sclk_fall in the same cycle: only the edge counted by the current state takes effect.
REQ-026 addr_we, sr_we, dm_we SHALL be mutually exclusive and registered (glitch-free).
REQ-027 Counter SHALL saturate at width; no wrap-around.

Reset
REQ-028 reset=1 SHALL force IDLE, counter=0, addr_we=sr_we=dm_we=miso_bufe=busy=0 immediately, independent of clk.
REQ-029 reset asserted mid-transaction SHALL abort without any strobe; after release, the controller waits in IDLE until cs_n is low.

Structure
REQ-030 State enum and the state encoding width SHALL live in shared package spi_ctrl_pkg.
REQ-031 Bit counting SHALL be a sub-module edge_bit_counter (clear, enable pulse, width parameter, done flag).
REQ-032 Outputs SHALL be decoded from registered state only (Moore).

Verification
REQ-033 Read: cs_n=0, 8 rises shifting 0x55 (rw_bit=1) -> addr_we pulse 1 cycle, sr_we pulse 2 cycles later, miso_bufe high for exactly 8 falls, then DONE.
REQ-034 Write: address 0x2A (rw_bit=0) plus 8 data rises -> addr_we once, dm_we once after the 8th data rise, miso_bufe never high.
REQ-035 Abort: cs_n=1 after 5 address rises -> IDLE next cycle, no strobes; a new transaction completes normally.
REQ-036 Reset: assert reset during READ_SHIFT at bit 3 -> miso_bufe=0 and busy=0 without a clk edge.
REQ-037 Overrun: 12 extra rises in DONE -> no strobes, counter unchanged; cs_n=1 -> IDLE.
REQ-038 Same cycle: cs_n=1 together with the 8th address sclk_rise -> IDLE, addr_we never asserted.
